// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: request-driven burst master for the multiplexed address/data RTC port
module rtc_bus_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int T_SU   = 1,
  parameter int T_STB  = 7,
  parameter int T_HLD  = 2,
  parameter int T_GAP  = 9
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              req,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_take,
  output logic              ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [LEN_W-1:0]  rd_index,
  output logic              CS,
  output logic              RD,
  output logic              WR,
  output logic              A_D,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in
);
  localparam int CW = $clog2(T_SU + T_STB + T_HLD + T_GAP + 1);
  localparam logic [CW-1:0] SU_L  = CW'(T_SU - 1);
  localparam logic [CW-1:0] STB_L = CW'(T_STB - 1);
  localparam logic [CW-1:0] HLD_L = CW'(T_HLD - 1);
  localparam logic [CW-1:0] GAP_L = CW'(T_GAP - 1);
  typedef enum logic [3:0] {IDLE, START, ASU, ASTB, AHLD, GAP, DSU, DSTB, DHLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic dir_q, dir_d, last, accept, next_beat, aph, dph, take_d, cap;
  always_comb begin
    lim = state_q inside {ASU, DSU} ? SU_L : state_q inside {ASTB, DSTB} ? STB_L :
          state_q inside {AHLD, DHLD} ? HLD_L : GAP_L;
    last = cnt_q == lim;
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = req ? START : IDLE;
      START:   state_d = ASU;
      ASU:     state_d = last ? ASTB : ASU;
      ASTB:    state_d = last ? AHLD : ASTB;
      AHLD:    state_d = last ? GAP : AHLD;
      GAP:     state_d = last ? DSU : GAP;
      DSU:     state_d = last ? DSTB : DSU;
      DSTB:    state_d = last ? DHLD : DSTB;
      DHLD:    state_d = !last ? DHLD : idx_q == len_q ? IDLE : ASU;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d == state_q ? cnt_q + 1'b1 : '0;
    accept = state_q == IDLE && req;
    next_beat = state_q == DHLD && state_d == ASU;
    dir_d = accept ? req_wr : dir_q;
    len_d = accept ? req_len : len_q;
    addr_d = accept ? req_addr : next_beat ? addr_q + 1'b1 : addr_q;
    idx_d = accept ? '0 : next_beat ? idx_q + 1'b1 : idx_q;
    aph = state_d inside {ASU, ASTB, AHLD};
    dph = state_d inside {DSU, DSTB, DHLD};
    take_d = dir_d && state_d == DSU && state_q != DSU;
    wd_d = take_d ? wdata : wd_q;
    cap = !dir_q && state_q == DSTB && last;
  end
  // Outputs are decoded from the next state so each register shows the state it is entering.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      wd_q <= '0;
      dir_q <= 1'b0;
      CS <= 1'b1;
      RD <= 1'b1;
      WR <= 1'b1;
      A_D <= 1'b1;
      bus_oe <= 1'b0;
      bus_out <= '0;
      ack <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      wdata_take <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_index <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      len_q <= len_d;
      idx_q <= idx_d;
      wd_q <= wd_d;
      dir_q <= dir_d;
      CS <= !(state_d inside {ASTB, DSTB});
      WR <= !(state_d == ASTB || (state_d == DSTB && dir_d));
      RD <= !(state_d == DSTB && !dir_d);
      A_D <= !aph;
      bus_oe <= aph || (dph && dir_d);
      bus_out <= aph ? addr_d : (dph && dir_d) ? wd_d : '0;
      ack <= state_d == START;
      busy <= !(state_d inside {IDLE, START});
      done <= state_q == DHLD && state_d == IDLE;
      wdata_take <= take_d;
      rd_valid <= cap;
      rd_data <= cap ? bus_in : rd_data;
      rd_index <= cap ? idx_q : rd_index;
    end
  end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: random and directed bursts checked cycle by cycle against a timing-arithmetic model
module tb_rtc_bus_sequencer;
  localparam int SU = 1, STB = 7, HLD = 2, GP = 9;
  localparam int A = SU + STB + HLD, BEAT = 2 * A + GP;
  localparam logic [9:0] IDLE_V = 10'b1111_000000;
  logic reloj = 0, resetM = 1, req = 0, req_wr = 0;
  logic [7:0] req_addr = 0, wdata = 0, bus_in = 0;
  logic [3:0] req_len = 0;
  logic wdata_take, ack, busy, done, rd_valid, CS, RD, WR, A_D, bus_oe;
  logic [7:0] rd_data, bus_out;
  logic [3:0] rd_index;
  int n_chk = 0, n_pass = 0;
  logic [7:0] wd[16], rdv[16];
  logic cur_wr;
  logic [7:0] cur_addr;
  int cur_len;
  always #5 reloj = ~reloj;
  rtc_bus_sequencer dut (
    .reloj(reloj), .resetM(resetM), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_len(req_len), .wdata(wdata), .wdata_take(wdata_take), .ack(ack), .busy(busy),
    .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index), .CS(CS),
    .RD(RD), .WR(WR), .A_D(A_D), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [31:0] ctl();
    return 32'({CS, RD, WR, A_D, bus_oe, ack, busy, done, wdata_take, rd_valid});
  endfunction
  // Expected outputs t cycles after the acceptance edge, from beat/offset arithmetic.
  task automatic model(input int t, output logic [9:0] v, output logic [7:0] bo,
                       output logic [7:0] rdd, output logic [3:0] ri);
    int b, o, d;
    logic sa, sd;
    v = IDLE_V; bo = 0; rdd = 0; ri = 0;
    if (t == 0) v[4] = 1'b1;
    else if (t == 1 + (cur_len + 1) * BEAT) v[2] = 1'b1;
    else begin
      b = (t - 1) / BEAT;
      o = (t - 1) % BEAT;
      d = o - A - GP;
      sa = o >= SU && o < SU + STB;
      sd = d >= SU && d < SU + STB;
      v = {!(sa || sd), !(sd && !cur_wr), !(sa || (sd && cur_wr)), !(o < A),
           (o < A) || (d >= 0 && cur_wr), 1'b0, 1'b1, 1'b0, cur_wr && d == 0,
           !cur_wr && d == SU + STB};
      bo = o < A ? cur_addr + 8'(b) : wd[b];
      rdd = rdv[b];
      ri = 4'(b);
    end
  endtask
  task automatic run(input logic wr, input logic [7:0] addr, input int len,
                     input logic hold, input int abort_at);
    logic [9:0] v;
    logic [7:0] bo, rdd;
    logic [3:0] ri;
    int last, b, n_done;
    cur_wr = wr; cur_addr = addr; cur_len = len;
    last = 1 + (len + 1) * BEAT;
    @(negedge reloj);
    req = 1; req_wr = wr; req_addr = addr; req_len = 4'(len);
    wdata = wd[0]; bus_in = rdv[0];
    @(posedge reloj);
    for (int t = 0; t <= last; t++) begin
      @(negedge reloj);
      model(t, v, bo, rdd, ri);
      check($sformatf("ctl t=%0d", t), ctl(), 32'(v));
      if (v[5]) check($sformatf("bus_out t=%0d", t), 32'(bus_out), 32'(bo));
      if (v[0]) begin
        check("rd_data", 32'(rd_data), 32'(rdd));
        check("rd_index", 32'(rd_index), 32'(ri));
      end
      req = hold;
      b = t / BEAT > len ? len : t / BEAT;
      wdata = wd[b];
      bus_in = rdv[b];
      if (t == abort_at) begin
        resetM = 1;
        @(negedge reloj);
        check("abort_ctl", ctl(), 32'(IDLE_V));
        resetM = 0;
        n_done = 0;
        repeat (40) begin
          @(negedge reloj);
          n_done += int'(done);
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        return;
      end
    end
    @(negedge reloj);
    check("ack_after_done", 32'(ack), 32'(hold));
    req = 0;
  endtask
  initial begin
    logic [7:0] a;
    repeat (3) @(posedge reloj);
    @(negedge reloj);
    check("rst_ctl", ctl(), 32'(IDLE_V));
    check("rst_bus_out", 32'(bus_out), 32'd0);
    check("rst_rd", 32'({rd_data, rd_index}), 32'd0);
    resetM = 0;
    wd[0] = 8'h45;
    run(1'b1, 8'h21, 0, 1'b0, -1);
    rdv[0] = 8'h59;
    run(1'b0, 8'h24, 0, 1'b0, -1);
    for (int i = 0; i < 16; i++) begin
      wd[i] = 8'($urandom);
      rdv[i] = 8'($urandom);
    end
    run(1'b0, 8'hFE, 2, 1'b0, -1);
    run(1'b1, 8'hFF, 1, 1'b0, -1);
    repeat (8) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = 8'($urandom);
        rdv[i] = 8'($urandom);
      end
      a = 8'($urandom);
      run(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 3)), 1'b0, -1);
    end
    run(1'b1, 8'h7C, 1, 1'b1, -1);
    @(negedge reloj);
    resetM = 1;
    @(negedge reloj);
    check("rst_pulse_ctl", ctl(), 32'(IDLE_V));
    resetM = 0;
    run(1'b1, 8'h10, 0, 1'b0, 23);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
